// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator with selectable test patterns.
// Produces a YCbCr pixel stream with de/hs/vs and a frame_start marker.
// Each line and each frame is laid out as active, front porch, sync, back porch.
// H_TOTAL and V_TOTAL must each be at most 4096, because the counters are 12 bits.
// The optional macro PATTERN_BORDER_EN forces luma to all-ones on the outermost
// active rows and columns.
`timescale 1ns/1ps
module video_pattern_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [1:0]             pattern_i,
    input  logic [PIXEL_WIDTH-1:0] solid_y_i,
    output logic [PIXEL_WIDTH-1:0] y_o,
    output logic [PIXEL_WIDTH-1:0] cb_o,
    output logic [PIXEL_WIDTH-1:0] cr_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   frame_start_o,
    output logic                   busy_o
);

    localparam int H_TOTAL_C = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_C = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST_C = 12'(H_TOTAL_C - 1);
    localparam logic [11:0] V_LAST_C = 12'(V_TOTAL_C - 1);

    // Region bounds are 13 bits so a total of exactly 4096 does not alias to 0.
    localparam logic [12:0] H_ACT_C      = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START_C   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END_C     = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_C      = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START_C   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END_C     = 13'(V_ACTIVE + V_FP + V_SYNC);

`ifdef PATTERN_BORDER_EN
    localparam logic [11:0] H_ACT_LAST_C = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_ACT_LAST_C = 12'(V_ACTIVE - 1);
`endif

    localparam logic [PIXEL_WIDTH-1:0] Y_ONES_C     = {PIXEL_WIDTH{1'b1}};
    localparam logic [PIXEL_WIDTH-1:0] Y_ZERO_C     = {PIXEL_WIDTH{1'b0}};
    localparam logic [PIXEL_WIDTH-1:0] CHROMA_MID_C = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};

    localparam logic [0:0] IDLE_C = 1'b0;
    localparam logic [0:0] RUN_C  = 1'b1;

    logic [0:0]             state_r;
    logic [11:0]            h_cnt_r;
    logic [11:0]            v_cnt_r;
    logic [PIXEL_WIDTH-1:0] frame_cnt_r;
    logic [1:0]             pattern_r;
    logic [PIXEL_WIDTH-1:0] solid_y_r;

    logic                   run_s;
    logic                   de_s;
    logic                   hs_s;
    logic                   vs_s;
    logic                   fs_s;
    logic [PIXEL_WIDTH-1:0] pix_s;
    logic [PIXEL_WIDTH-1:0] y_nxt_s;
    logic [PIXEL_WIDTH-1:0] c_nxt_s;
    logic [12:0]            h_ext_s;
    logic [12:0]            v_ext_s;

    // Run/idle control, raster counters, frame counter and per-frame pattern latch.
    // The pattern is captured on the edge where the counters move to (0,0),
    // so the whole frame that starts there uses a single pattern setting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE_C;
            h_cnt_r     <= 12'd0;
            v_cnt_r     <= 12'd0;
            frame_cnt_r <= Y_ZERO_C;
            pattern_r   <= 2'd0;
            solid_y_r   <= Y_ZERO_C;
        end else begin
            case (state_r)
                IDLE_C: begin
                    h_cnt_r <= 12'd0;
                    v_cnt_r <= 12'd0;
                    if (en_i) begin
                        state_r   <= RUN_C;
                        pattern_r <= pattern_i;
                        solid_y_r <= solid_y_i;
                    end else begin
                        state_r <= IDLE_C;
                    end
                end
                RUN_C: begin
                    if (h_cnt_r == H_LAST_C) begin
                        h_cnt_r <= 12'd0;
                        if (v_cnt_r == V_LAST_C) begin
                            v_cnt_r     <= 12'd0;
                            frame_cnt_r <= frame_cnt_r + {{(PIXEL_WIDTH-1){1'b0}}, 1'b1};
                            pattern_r   <= pattern_i;
                            solid_y_r   <= solid_y_i;
                            if (en_i) begin
                                state_r <= RUN_C;
                            end else begin
                                state_r <= IDLE_C;
                            end
                        end else begin
                            v_cnt_r <= v_cnt_r + 12'd1;
                        end
                    end else begin
                        h_cnt_r <= h_cnt_r + 12'd1;
                    end
                end
                default: begin
                    state_r <= IDLE_C;
                    h_cnt_r <= 12'd0;
                    v_cnt_r <= 12'd0;
                end
            endcase
        end
    end

    // Decode the current raster position into timing flags and a pixel value.
    always_comb begin
        run_s   = (state_r == RUN_C);
        h_ext_s = {1'b0, h_cnt_r};
        v_ext_s = {1'b0, v_cnt_r};
        de_s    = run_s && (h_ext_s < H_ACT_C) && (v_ext_s < V_ACT_C);
        hs_s    = run_s && (h_ext_s >= HS_START_C) && (h_ext_s < HS_END_C);
        vs_s    = run_s && (v_ext_s >= VS_START_C) && (v_ext_s < VS_END_C);
        fs_s    = run_s && (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
        pix_s   = Y_ZERO_C;
        case (pattern_r)
            2'd0:    pix_s = solid_y_r;
            2'd1:    pix_s = h_cnt_r[PIXEL_WIDTH-1:0];
            2'd2:    pix_s = (h_cnt_r[4] ^ v_cnt_r[4]) ? Y_ONES_C : Y_ZERO_C;
            2'd3:    pix_s = h_cnt_r[PIXEL_WIDTH-1:0] + frame_cnt_r;
            default: pix_s = Y_ZERO_C;
        endcase
`ifdef PATTERN_BORDER_EN
        if ((h_cnt_r == 12'd0) || (h_cnt_r == H_ACT_LAST_C) ||
            (v_cnt_r == 12'd0) || (v_cnt_r == V_ACT_LAST_C)) begin
            pix_s = Y_ONES_C;
        end else begin
            pix_s = pix_s;
        end
`endif
        if (de_s) begin
            y_nxt_s = pix_s;
            c_nxt_s = CHROMA_MID_C;
        end else begin
            y_nxt_s = Y_ZERO_C;
            c_nxt_s = Y_ZERO_C;
        end
    end

    // Output register stage: everything leaves the block one clock after decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_o           <= Y_ZERO_C;
            cb_o          <= Y_ZERO_C;
            cr_o          <= Y_ZERO_C;
            de_o          <= 1'b0;
            hs_o          <= 1'b0;
            vs_o          <= 1'b0;
            frame_start_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            y_o           <= y_nxt_s;
            cb_o          <= c_nxt_s;
            cr_o          <= c_nxt_s;
            de_o          <= de_s;
            hs_o          <= hs_s;
            vs_o          <= vs_s;
            frame_start_o <= fs_s;
            busy_o        <= run_s;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed bench for video_pattern_gen.
// Instance s: tiny raster 8/2/2/2 x 4/1/1/1, checked clock-by-clock.
// Instance d: default 640x480 timing, used for the h-ramp.
// Instance m: 40/2/4/2 x 20/1/2/1 raster, used for the moving ramp,
//             the mid-frame pattern change and reset.
// When PATTERN_BORDER_EN is defined, the expected luma follows the border rule.
`timescale 1ns/1ps
module tb_video_pattern_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en_s, en_d, en_m;
    logic [1:0] pat_s, pat_d, pat_m;
    logic [7:0] sol_s, sol_d, sol_m;
    logic [7:0] y_s, cb_s, cr_s, y_d, cb_d, cr_d, y_m, cb_m, cr_m;
    logic       de_s, hs_s, vs_s, fs_s, busy_s;
    logic       de_d, hs_d, vs_d, fs_d, busy_d;
    logic       de_m, hs_m, vs_m, fs_m, busy_m;

    int n_tests = 0;
    int n_fail  = 0;
    int mpos    = 0;
    int hh, vv;
    logic act;
    logic [7:0] ey;

    video_pattern_gen #(.PIXEL_WIDTH(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_s (
        .clk(clk), .rst(rst), .en_i(en_s), .pattern_i(pat_s), .solid_y_i(sol_s),
        .y_o(y_s), .cb_o(cb_s), .cr_o(cr_s), .de_o(de_s), .hs_o(hs_s), .vs_o(vs_s),
        .frame_start_o(fs_s), .busy_o(busy_s));

    video_pattern_gen u_d (
        .clk(clk), .rst(rst), .en_i(en_d), .pattern_i(pat_d), .solid_y_i(sol_d),
        .y_o(y_d), .cb_o(cb_d), .cr_o(cr_d), .de_o(de_d), .hs_o(hs_d), .vs_o(vs_d),
        .frame_start_o(fs_d), .busy_o(busy_d));

    video_pattern_gen #(.PIXEL_WIDTH(8), .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
                        .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_m (
        .clk(clk), .rst(rst), .en_i(en_m), .pattern_i(pat_m), .solid_y_i(sol_m),
        .y_o(y_m), .cb_o(cb_m), .cr_o(cr_m), .de_o(de_m), .hs_o(hs_m), .vs_o(vs_m),
        .frame_start_o(fs_m), .busy_o(busy_m));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Expected luma of an active pixel given the pattern value.
    function automatic logic [7:0] pix_fn(input logic [7:0] base, input int h, input int v,
                                          input int ha, input int va);
`ifdef PATTERN_BORDER_EN
        if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) return 8'hFF;
`endif
        return base;
    endfunction

    // Advance instance m so its outputs reflect raster index target.
    task automatic m_goto(input int target);
        while (mpos < target) begin
            tick();
            mpos++;
        end
    endtask

    initial begin
        en_s = 1'b0; en_d = 1'b0; en_m = 1'b0;
        pat_s = 2'd0; pat_d = 2'd0; pat_m = 2'd0;
        sol_s = 8'h00; sol_d = 8'h00; sol_m = 8'h00;

        // Asynchronous reset with no clock edge in between.
        #1 rst = 1'b0;
        #2;
        chk("rst.y", 0, y_s, 8'h00);
        chk("rst.de", 0, de_s, 1'b0);
        chk("rst.busy", 0, busy_s, 1'b0);
        chk("rst.cb", 0, cb_s, 8'h00);
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk("idle.de", 0, de_s, 1'b0);
        chk("idle.busy", 0, busy_s, 1'b0);

        // Small raster, solid 0x40.
        pat_s = 2'd0; sol_s = 8'h40; en_s = 1'b1;
        tick();
        chk("s.fs_early", 0, fs_s, 1'b0);
        chk("s.de_early", 0, de_s, 1'b0);
        tick();
        for (int k = 0; k < 294; k++) begin
            hh  = k % 14;
            vv  = (k / 14) % 7;
            act = (hh < 8) && (vv < 4);
            ey  = act ? pix_fn(8'h40, hh, vv, 8, 4) : 8'h00;
            chk("s.y", k, y_s, ey);
            chk("s.cb", k, cb_s, act ? 8'h80 : 8'h00);
            chk("s.cr", k, cr_s, act ? 8'h80 : 8'h00);
            chk("s.de", k, de_s, act);
            chk("s.hs", k, hs_s, (hh >= 10) && (hh < 12));
            chk("s.vs", k, vs_s, vv == 5);
            chk("s.fs", k, fs_s, (hh == 0) && (vv == 0));
            chk("s.busy", k, busy_s, 1'b1);
            if (k == 230) en_s = 1'b0;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk("s.off_busy", k, busy_s, 1'b0);
            chk("s.off_de", k, de_s, 1'b0);
            chk("s.off_y", k, y_s, 8'h00);
            chk("s.off_fs", k, fs_s, 1'b0);
            tick();
        end

        // Default timing, horizontal ramp over two lines.
        pat_d = 2'd1; en_d = 1'b1;
        tick(); tick();
        for (int k = 0; k < 1600; k++) begin
            hh  = k % 800;
            vv  = k / 800;
            act = hh < 640;
            ey  = act ? pix_fn(8'(hh), hh, vv, 640, 480) : 8'h00;
            chk("d.y", k, y_d, ey);
            chk("d.de", k, de_d, act);
            tick();
        end

        // Medium raster: moving ramp, then solid, then checker.
        pat_m = 2'd3; sol_m = 8'h40; en_m = 1'b1;
        tick(); tick();
        mpos = 0;
        chk("m.f0p0", mpos, y_m, pix_fn(8'h00, 0, 0, 40, 20));
        chk("m.f0fs", mpos, fs_m, 1'b1);
        chk("m.f0cb", mpos, cb_m, 8'h80);
        m_goto(53);
        chk("m.f0l1p5", mpos, y_m, pix_fn(8'h05, 5, 1, 40, 20));
        m_goto(1152);
        chk("m.f1p0", mpos, y_m, pix_fn(8'h01, 0, 0, 40, 20));
        chk("m.f1fs", mpos, fs_m, 1'b1);
        m_goto(1205);
        chk("m.f1l1p5", mpos, y_m, pix_fn(8'h06, 5, 1, 40, 20));
        pat_m = 2'd0;
        m_goto(1212);
        chk("m.f1hold", mpos, y_m, pix_fn(8'h0D, 12, 1, 40, 20));
        m_goto(2304);
        chk("m.f2p0", mpos, y_m, pix_fn(8'h40, 0, 0, 40, 20));
        m_goto(2357);
        chk("m.f2l1p5", mpos, y_m, pix_fn(8'h40, 5, 1, 40, 20));
        pat_m = 2'd2;
        m_goto(2404);
        chk("m.f2hold", mpos, y_m, pix_fn(8'h40, 4, 2, 40, 20));
        m_goto(3456);
        chk("m.f3p0", mpos, y_m, pix_fn(8'h00, 0, 0, 40, 20));
        m_goto(3472);
        chk("m.f3p16", mpos, y_m, pix_fn(8'hFF, 16, 0, 40, 20));
        m_goto(3496);
        chk("m.f3h40y", mpos, y_m, 8'h00);
        chk("m.f3h40de", mpos, de_m, 1'b0);
        m_goto(3498);
        chk("m.f3h42hs", mpos, hs_m, 1'b1);
        m_goto(3505);
        chk("m.f3l1p1", mpos, y_m, pix_fn(8'h00, 1, 1, 40, 20));
        m_goto(3521);
        chk("m.f3l1p17", mpos, y_m, pix_fn(8'hFF, 17, 1, 40, 20));
        m_goto(4225);
        chk("m.f3l16p1", mpos, y_m, pix_fn(8'hFF, 1, 16, 40, 20));
        chk("m.busy", mpos, busy_m, 1'b1);

        // Reset asserted mid-line takes effect without a clock edge.
        rst = 1'b0;
        #2;
        chk("m.rst_y", 0, y_m, 8'h00);
        chk("m.rst_de", 0, de_m, 1'b0);
        chk("m.rst_cb", 0, cb_m, 8'h00);
        chk("m.rst_busy", 0, busy_m, 1'b0);
        chk("d.rst_de", 0, de_d, 1'b0);
        tick();
        rst = 1'b1;
        en_m = 1'b0; en_d = 1'b0;
        tick(); tick();
        chk("m.post_busy", 0, busy_m, 1'b0);
        chk("m.post_de", 0, de_m, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Source end of the pixel stream interface (y/cb/cr + de/hs/vs) consumed by the video filters (brightness etc.).
- Generates raster timing from horizontal/vertical counters and fills active video with a selectable test pattern.
- Used as bench stimulus and as the on-board fallback source ahead of the filter chain.

Parameters:
PIXEL_WIDTH, 8, component bit width
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-low
en_i  in  1  run request
pattern_i  in  2  0 solid, 1 h-ramp, 2 checker, 3 moving ramp
solid_y_i  in  PIXEL_WIDTH  luma for the solid pattern
y_o  out  PIXEL_WIDTH  luma
cb_o  out  PIXEL_WIDTH  chroma blue
cr_o  out  PIXEL_WIDTH  chroma red
de_o  out  1  data enable, active-high
hs_o  out  1  hsync, active-high
vs_o  out  1  vsync, active-high
frame_start_o  out  1  one-clock pulse coincident with the first active pixel of a frame
busy_o  out  1  high while in RUN

Behaviour:
- Reset (rst=0, async): all outputs 0; h_cnt=v_cnt=0; frame_cnt=0; state IDLE.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters are 12 bits wide; H_TOTAL and V_TOTAL must be at most 4096.
- State machine:
  - IDLE: counters held at 0; all outputs driven 0. en_i=1 -> RUN on the next clock, counting from h=0, v=0.
  - RUN: h_cnt increments every clock and wraps H_TOTAL-1 -> 0. On wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - At the last clock of a frame (h=H_TOTAL-1, v=V_TOTAL-1): en_i=0 -> IDLE; otherwise continue. Frames always complete. en_i is ignored elsewhere in RUN.
- Regions per line/frame: active first, then front porch, sync, back porch.
  - de = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vs is asserted for whole lines, including the porch clocks.
- Latency: all outputs registered; output at cycle n+1 reflects counter values at cycle n. The first de_o/frame_start_o pulse appears 2 clocks after en_i is sampled high in IDLE.
- Pattern select: pattern_i and solid_y_i are latched into internal registers when h=0, v=0 in RUN (and on the IDLE->RUN transition). Changes mid-frame take effect on the next frame.
- Pixel values, active only. Outside active video, y/cb/cr = 0.
  - Chroma: cb_o = cr_o = 2^(PIXEL_WIDTH-1) for all patterns.
  - 0: y = latched solid_y.
  - 1: y = h[PIXEL_WIDTH-1:0]; wraps naturally.
  - 2: y = all-ones if h[4]^v[4], else 0 (16x16 checker).
  - 3: y = (h + frame_cnt) truncated to PIXEL_WIDTH.
- frame_cnt: increments (modulo 2^PIXEL_WIDTH) at each frame wrap in RUN; cleared only by reset.
- busy_o = registered (state==RUN).
- Reset mid-frame: immediate return to the reset values; no partial-frame completion.

Optional Feature:
PATTERN_BORDER_EN
- Defined: active pixels on the first or last active line, or the first or last active column, output y = all-ones. This overrides every pattern; chroma is unchanged.
- Undefined: no border logic; pattern output as specified above.

Test Plan:
- Reset then en_i=1 with H 8/2/2/2, V 4/1/1/1, pattern 0, solid_y=0x40 -> de_o high 8 clocks per line for 4 lines; y=0x40, cb=cr=0x80; hs_o 2 clocks at h=10..11; vs_o for all 14 clocks of line 5; frame_start_o one pulse per 14x7=98 clocks, 2 clocks after en_i.
- Pattern 1, default timing -> y_o sequence 0x00..0xFF, 0x00..0xFF, 0x00..0x7F per line (640 px).
- Pattern 3 over two frames -> line 0 pixel 0 y=0x00 in frame 0 and 0x01 in frame 1.
- pattern_i changed 0->2 mid-frame -> current frame stays solid; next frame is checker (pixel 16 of line 0 = 0xFF, pixel 0 = 0x00).
- en_i dropped mid-frame -> frame completes, then all outputs 0 and busy_o=0; rst pulsed low mid-line -> outputs 0 asynchronously, with no clock required.
- PATTERN_BORDER_EN defined, pattern 0 solid 0x40 -> border pixels 0xFF, interior 0x40.
